spi_job_scheduler: RTL
======================

# spi_job_scheduler

Sequencer and two-requester arbiter for the pseudo-SPI serializer. It accepts transfer jobs (SRAM start address, length, clock divider) from two requesters and arbitrates between them round-robin. For each job it drives the serializer's parameter bus and level-sensitive BGN with correct setup, waits for the serializer's done flag under a watchdog, and returns a per-requester completion pulse with an error flag.

## Interface
Parameters:
- ADDR_WIDTH, 9, SRAM address width; matches the serializer's MEMORY_ADDR_WIDTH.
- LEN_WIDTH, 8, job length width; matches RESERVED_DATA_LEN.
- SETUP_CYCLES, 2, cycles the parameters are held with BGN low before BGN rises; legal range 1..15.
- TIMEOUT, 16'd4096, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ0 / REQ1  in  1  job request, level; held until the matching DONEx.
- ADDR0 / ADDR1  in  ADDR_WIDTH  job start address; sampled at grant.
- LEN0 / LEN1  in  LEN_WIDTH  job length in words; sampled at grant.
- DIV0 / DIV1  in  8  job clock divider; sampled at grant.
- ABORT  in  1  forces the current job to end with an error.
- SPI_DONE  in  1  serializer done flag; level, valid only while BGN=1.
- BGN  out  1  serializer run enable. Low holds the serializer in reset and loads parameters.
- ADDR_BGN  out  ADDR_WIDTH  latched start address.
- DATA_LEN  out  LEN_WIDTH  latched length.
- FREQ_DIV  out  8  latched divider.
- GNT0 / GNT1  out  1  one-cycle pulse: the job has been accepted.
- DONE0 / DONE1  out  1  one-cycle pulse: the job has finished.
- ERR  out  1  valid only with DONEx; 1 means the job ended by timeout or abort.
- BUSY  out  1  high in every state except IDLE.
- OWNER  out  1  index of the current or last granted requester.

## Operation
- States: IDLE, SETUP, RUN, FIN.
- IDLE: BGN=0. If any REQ is high, choose a winner and load ADDR_BGN/DATA_LEN/FREQ_DIV from the winner's inputs. Set OWNER to the winner and go to SETUP.
- Arbitration is round-robin. With both requests high, the requester that is not OWNER wins. With a single request, that requester wins.
- SETUP: BGN=0 and parameters stable. A setup counter loads SETUP_CYCLES-1 on entry. When the counter reaches 0, go to RUN.
- SPI_DONE is ignored in SETUP; it is stale from the previous job.
- RUN: BGN=1. The watchdog counter is cleared on SETUP entry and increments once per RUN cycle.
  - SPI_DONE=1: go to FIN with err=0.
  - TIMEOUT≠0 and watchdog = TIMEOUT-1: go to FIN with err=1.
  - SPI_DONE and timeout in the same cycle: success wins, err=0.
- ABORT=1 in SETUP or RUN: go to FIN with err=1. ABORT takes priority over SPI_DONE. ABORT in IDLE or FIN is ignored.
- FIN: BGN=0. DONE[OWNER]=1 and ERR=err for exactly this cycle. Next state is IDLE.
- A requester may keep REQ high after DONEx to chain a job. Round-robin still applies.
- Parameter outputs hold their last value in IDLE. They change only at a grant.

## Timing
- Reset values: BGN=0, ADDR_BGN=0, DATA_LEN=0, FREQ_DIV=0, GNT0=GNT1=0, DONE0=DONE1=0, ERR=0, BUSY=0, OWNER=1 (so REQ0 wins the first tie). State resets to IDLE.
- All outputs are registered.
- REQx sampled high in IDLE at edge t:
  - parameters are valid from t+1;
  - GNTx=1 during cycle t+1 (first SETUP cycle);
  - BGN rises at edge t+SETUP_CYCLES.
- SPI_DONE sampled high at edge r: during cycle r+1, BGN=0 and DONEx=1. The earliest next grant edge is r+2.
- Minimum job period with an immediate SPI_DONE: SETUP_CYCLES+3 cycles.
- Reset mid-job: BGN drops asynchronously. No DONE pulse is issued. Requesters must re-request.

## Test plan
- Single job, SETUP_CYCLES=2.
  - Stimulus: REQ0 with ADDR0=9'h1F0, LEN0=8, DIV0=3; SPI_DONE asserted 20 cycles after BGN rises.
  - Required: GNT0 one cycle after REQ; parameters stable ≥2 cycles before BGN; DONE0 one cycle after SPI_DONE, with ERR=0 and BGN=0 on that cycle.
- Contention: REQ0 and REQ1 high together from reset, each held through its job and re-raised immediately.
  - Required: grants alternate 0,1,0,1; no overlapping BGN pulses; at least 1 BGN-low FIN cycle between jobs.
- Timeout: TIMEOUT=16, SPI_DONE never asserted.
  - Required: BGN high exactly 16 cycles, then DONEx with ERR=1.
  - Same cycle SPI_DONE and timeout: ERR=0.
- Abort:
  - ABORT pulsed in SETUP: BGN never rises; DONEx with ERR=1.
  - ABORT pulsed together with SPI_DONE in RUN: ERR=1.
  - ABORT in IDLE: no effect.
- Stale done: SPI_DONE held high through SETUP.
  - Required: no exit before RUN; job completes on the first RUN cycle.
- Reset mid-RUN: RST_N low for 1 cycle.
  - Required: BGN=0 immediately and all outputs at reset values; a pending REQ1 is then served first-tie as REQ0-priority per OWNER=1.

Source files
------------

// File: rtl/spi_job_scheduler.sv
// spi_job_scheduler: two-requester round-robin arbiter and job sequencer
// for the pseudo-SPI serializer. Each accepted job has its parameters
// latched and held with BGN low for a setup window. BGN then runs until
// the serializer reports done, the watchdog expires, or ABORT arrives.
// A completion pulse with an error flag goes back to the job's owner.
module spi_job_scheduler #(
  parameter int          ADDR_WIDTH   = 9,
  parameter int          LEN_WIDTH    = 8,
  parameter int          SETUP_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd4096
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [LEN_WIDTH-1:0]  LEN0,
  input  logic [LEN_WIDTH-1:0]  LEN1,
  input  logic [7:0]            DIV0,
  input  logic [7:0]            DIV1,
  input  logic                  ABORT,
  input  logic                  SPI_DONE,
  output logic                  BGN,
  output logic [ADDR_WIDTH-1:0] ADDR_BGN,
  output logic [LEN_WIDTH-1:0]  DATA_LEN,
  output logic [7:0]            FREQ_DIV,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  OWNER
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  setup_cnt;
  logic [15:0] wdog;
  logic        winner;
  logic        timeout_hit;
  logic        fin_go;
  logic        fin_err;

  // Pick the next owner: on a tie the requester that did not go last wins
  always_comb begin
    winner = REQ1;
    if (REQ0 && REQ1) begin
      winner = ~OWNER;
    end
  end

  // Watchdog expiry; a zero limit disables it entirely
  always_comb begin
    timeout_hit = (TIMEOUT != 16'd0) && (wdog == (TIMEOUT - 16'd1));
  end

  // Decide whether the current job ends this cycle and with what error.
  // ABORT beats SPI_DONE, and SPI_DONE beats a coincident timeout.
  // SPI_DONE in SETUP is left over from the previous job and is ignored.
  always_comb begin
    fin_go  = 1'b0;
    fin_err = 1'b0;
    case (state)
      ST_SETUP: begin
        if (ABORT) begin
          fin_go  = 1'b1;
          fin_err = 1'b1;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          fin_go  = 1'b1;
          fin_err = 1'b1;
        end else if (SPI_DONE) begin
          fin_go  = 1'b1;
          fin_err = 1'b0;
        end else if (timeout_hit) begin
          fin_go  = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: begin
        fin_go  = 1'b0;
        fin_err = 1'b0;
      end
    endcase
  end

  // Sequencer: state, counters and every registered output
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      setup_cnt <= '0;
      wdog      <= '0;
      BGN       <= 1'b0;
      ADDR_BGN  <= '0;
      DATA_LEN  <= '0;
      FREQ_DIV  <= '0;
      GNT0      <= 1'b0;
      GNT1      <= 1'b0;
      DONE0     <= 1'b0;
      DONE1     <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      OWNER     <= 1'b1;
    end else begin
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      ERR   <= 1'b0;
      if (fin_go) begin
        state <= ST_FIN;
        BGN   <= 1'b0;
        DONE0 <= ~OWNER;
        DONE1 <= OWNER;
        ERR   <= fin_err;
      end else begin
        case (state)
          ST_IDLE: begin
            if (REQ0 || REQ1) begin
              OWNER     <= winner;
              GNT0      <= ~winner;
              GNT1      <= winner;
              ADDR_BGN  <= winner ? ADDR1 : ADDR0;
              DATA_LEN  <= winner ? LEN1 : LEN0;
              FREQ_DIV  <= winner ? DIV1 : DIV0;
              setup_cnt <= 4'(SETUP_CYCLES - 1);
              wdog      <= '0;
              BUSY      <= 1'b1;
              state     <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (setup_cnt == 4'd0) begin
              BGN   <= 1'b1;
              state <= ST_RUN;
            end else begin
              setup_cnt <= setup_cnt - 4'd1;
            end
          end
          ST_RUN: begin
            wdog <= wdog + 16'd1;
          end
          ST_FIN: begin
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            BGN   <= 1'b0;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
